// File: rtl/avalon_mm_arbiter_if.sv
// Bus bundle for avalon_mm_arbiter: requester-side and shared-slave-side signals.
// modport master : the arbiter (drives the shared slave and the requester responses)
// modport slave  : the environment (requesters plus the shared slave)
interface avalon_mm_arbiter_if #(
   parameter int unsigned NUM_MASTERS = 4
);
   logic [NUM_MASTERS-1:0]   mst_read;
   logic [NUM_MASTERS-1:0]   mst_write;
   logic [8*NUM_MASTERS-1:0] mst_address;
   logic [8*NUM_MASTERS-1:0] mst_writedata;
   logic [NUM_MASTERS-1:0]   mst_waitrequest;
   logic [7:0]               mst_readdata;
   logic [7:0]               slv_address;
   logic [7:0]               slv_writedata;
   logic                     slv_read;
   logic                     slv_write;
   logic                     slv_waitrequest;
   logic [7:0]               slv_readdata;
   logic [NUM_MASTERS-1:0]   grant;
   logic                     timeout_err;

   modport master (
      input  mst_read, mst_write, mst_address, mst_writedata,
      input  slv_waitrequest, slv_readdata,
      output mst_waitrequest, mst_readdata,
      output slv_address, slv_writedata, slv_read, slv_write,
      output grant, timeout_err
   );

   modport slave (
      output mst_read, mst_write, mst_address, mst_writedata,
      output slv_waitrequest, slv_readdata,
      input  mst_waitrequest, mst_readdata,
      input  slv_address, slv_writedata, slv_read, slv_write,
      input  grant, timeout_err
   );
endinterface

// File: rtl/avalon_mm_arbiter.sv
// Round-robin arbiter sharing one Avalon-MM slave among NUM_MASTERS requesters.
// FSM IDLE -> ISSUE -> DONE; all slave-side outputs and mst_readdata registered.
// Optional feature macro: AVMM_ARB_TIMEOUT_EN (abort a stalled slave access
// after TIMEOUT_CYCLES waitrequest cycles, return 0xFF, set sticky timeout_err).
module avalon_mm_arbiter #(
   parameter int unsigned NUM_MASTERS    = 4,
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic                clk,
   input  logic                reset_n,
   avalon_mm_arbiter_if.master bus
);
   localparam int unsigned PTR_W = $clog2(NUM_MASTERS);

   if (NUM_MASTERS < 2 || NUM_MASTERS > 8 || TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_param_check
      $error("avalon_mm_arbiter: parameter out of range");
   end

   typedef enum logic [1:0] {IDLE, ISSUE, DONE} state_t;

   state_t                 state_q, state_d;
   logic                   arb_en_q, arb_en_d;
   logic [PTR_W-1:0]       rr_ptr_q, rr_ptr_d;
   logic [PTR_W-1:0]       owner_q, owner_d;
   logic [NUM_MASTERS-1:0] grant_q, grant_d;
   logic [NUM_MASTERS-1:0] mst_wait_q, mst_wait_d;
   logic [7:0]             rdata_q, rdata_d;
   logic [7:0]             slv_addr_q, slv_addr_d;
   logic [7:0]             slv_wdata_q, slv_wdata_d;
   logic                   slv_read_q, slv_read_d;
   logic                   slv_write_q, slv_write_d;

   logic [NUM_MASTERS-1:0] req;
   logic                   win_found;
   logic [PTR_W-1:0]       win_idx;
   int unsigned            win_sel;
   int unsigned            scan_idx;
   logic                   start;
   logic                   finish;
   logic                   timed_out;

   assign req    = bus.mst_read | bus.mst_write;
   assign start  = (state_q == IDLE) && arb_en_q && win_found;
   assign finish = (state_q == ISSUE) && (!bus.slv_waitrequest || timed_out);

   // round-robin search: first requester at or after rr_ptr, wrapping to 0
   always_comb begin
      win_found = 1'b0;
      win_idx   = '0;
      scan_idx  = 0;
      for (int unsigned k = 0; k < NUM_MASTERS; k++) begin
         scan_idx = 32'(rr_ptr_q) + k;
         if (scan_idx >= NUM_MASTERS) scan_idx = scan_idx - NUM_MASTERS;
         if (!win_found && req[scan_idx]) begin
            win_found = 1'b1;
            win_idx   = PTR_W'(scan_idx);
         end
      end
      win_sel = 32'(win_idx);
   end

`ifdef AVMM_ARB_TIMEOUT_EN
   logic [7:0] to_cnt_q, to_cnt_d;
   logic       timeout_err_q, timeout_err_d;

   assign timed_out = (state_q == ISSUE) && bus.slv_waitrequest &&
                      (to_cnt_q == 8'(TIMEOUT_CYCLES - 1));

   // wait counter runs only while a command is outstanding; error flag is sticky
   always_comb begin
      to_cnt_d      = (state_q == ISSUE) ? to_cnt_q + 8'd1 : '0;
      timeout_err_d = timeout_err_q | timed_out;
   end

   // timeout counter and sticky error registers
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         to_cnt_q      <= '0;
         timeout_err_q <= 1'b0;
      end else begin
         to_cnt_q      <= to_cnt_d;
         timeout_err_q <= timeout_err_d;
      end
   end

   assign bus.timeout_err = timeout_err_q;
`else
   assign timed_out       = 1'b0;
   assign bus.timeout_err = 1'b0;
`endif

   // state register; arb_en holds off arbitration for the first edge after reset release
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= IDLE;
         arb_en_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         arb_en_q <= arb_en_d;
      end
   end

   // next-state logic
   always_comb begin
      state_d  = state_q;
      arb_en_d = 1'b1;
      case (state_q)
         IDLE:    if (start)  state_d = ISSUE;
         ISSUE:   if (finish) state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // output/datapath next values (all registered below)
   always_comb begin
      rr_ptr_d    = rr_ptr_q;
      owner_d     = owner_q;
      grant_d     = grant_q;
      mst_wait_d  = mst_wait_q;
      rdata_d     = rdata_q;
      slv_addr_d  = slv_addr_q;
      slv_wdata_d = slv_wdata_q;
      slv_read_d  = slv_read_q;
      slv_write_d = slv_write_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               owner_d          = win_idx;
               grant_d          = '0;
               grant_d[win_idx] = 1'b1;
               slv_addr_d       = bus.mst_address[8*win_sel +: 8];
               slv_wdata_d      = bus.mst_writedata[8*win_sel +: 8];
               // write has priority when both strobes are raised together
               slv_write_d      = bus.mst_write[win_idx];
               slv_read_d       = bus.mst_read[win_idx] & ~bus.mst_write[win_idx];
            end
         end
         ISSUE: begin
            if (finish) begin
               slv_read_d          = 1'b0;
               slv_write_d         = 1'b0;
               mst_wait_d          = '1;
               mst_wait_d[owner_q] = 1'b0;
               if (timed_out)       rdata_d = 8'hFF;
               else if (slv_read_q) rdata_d = bus.slv_readdata;
               else                 rdata_d = 8'h00;
            end
         end
         DONE: begin
            mst_wait_d = '1;
            grant_d    = '0;
            rr_ptr_d   = (owner_q == PTR_W'(NUM_MASTERS - 1)) ? '0 : owner_q + PTR_W'(1);
         end
         default: ;
      endcase
   end

   // registered outputs and arbitration bookkeeping
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rr_ptr_q    <= '0;
         owner_q     <= '0;
         grant_q     <= '0;
         mst_wait_q  <= '1;
         rdata_q     <= '0;
         slv_addr_q  <= '0;
         slv_wdata_q <= '0;
         slv_read_q  <= 1'b0;
         slv_write_q <= 1'b0;
      end else begin
         rr_ptr_q    <= rr_ptr_d;
         owner_q     <= owner_d;
         grant_q     <= grant_d;
         mst_wait_q  <= mst_wait_d;
         rdata_q     <= rdata_d;
         slv_addr_q  <= slv_addr_d;
         slv_wdata_q <= slv_wdata_d;
         slv_read_q  <= slv_read_d;
         slv_write_q <= slv_write_d;
      end
   end

   assign bus.grant           = grant_q;
   assign bus.mst_waitrequest = mst_wait_q;
   assign bus.mst_readdata    = rdata_q;
   assign bus.slv_address     = slv_addr_q;
   assign bus.slv_writedata   = slv_wdata_q;
   assign bus.slv_read        = slv_read_q;
   assign bus.slv_write       = slv_write_q;
endmodule
